alsu_gen2: RTL and testbench
============================

ALSU_GEN2 -- requirements
Module: alsu_gen2

Interface
REQ-001 Parameter WIDTH, default 4: operand width; must be ≥2.
REQ-002 Parameter INPUT_PRIORITY, default "A": selects which operand wins when both bypass flags or both reduction flags are set ("A" or "B").
REQ-003 Parameter FULL_ADDER, default "ON": "ON" adds cin in opcode 2; any other value ignores cin.
REQ-004 Parameter SATURATE, default 1: 1 = opcode 6 saturates; 0 = opcode 6 wraps.
REQ-005 Derived width OUT_W = 2*WIDTH.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset: asynchronous, active-high.
REQ-008 in_valid  in  1  input transaction present.
REQ-009 in_ready  out  1  block can accept an input transaction.
REQ-010 A, B  in  WIDTH  signed operands.
REQ-011 cin  in  2  signed carry-in.
REQ-012 serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  mode controls.
REQ-013 opcode  in  3  operation select.
REQ-014 out  out  OUT_W  signed result register; doubles as shift/rotate/accumulate state.
REQ-015 out_valid  out  1  out holds a result not yet consumed.
REQ-016 out_ready  in  1  downstream consumes out.
REQ-017 leds  out  16  invalid-operation indicator.
REQ-018 err_count  out  8  saturating count of invalid operations.

Function
REQ-019 Accept = in_valid & in_ready; on accept, all inputs other than out_ready are captured into stage-1 registers and s1_valid is set.
REQ-020 in_ready = !s1_valid | !out_valid | out_ready (combinational).
REQ-021 Issue = s1_valid & (!out_valid | out_ready); on issue, out is updated from stage-1 values, out_valid=1, and s1_valid clears unless there is an accept in the same cycle.
REQ-022 Consume = out_valid & out_ready without issue: out_valid clears; out retains its value.
REQ-023 Latency: accept at edge N -> out_valid=1 after edge N+1 with no backpressure; throughput is 1 transaction/cycle.
REQ-024 While out_valid=1 and out_ready=0, out shall not change.
REQ-025 invalid = ((red_op_A|red_op_B) & opcode in 2..7) | (opcode==7), evaluated on stage-1 values.
REQ-026 Result priority:
  - both bypass flags set: the operand selected by INPUT_PRIORITY;
  - else bypass_A: A;
  - else bypass_B: B;
  - else invalid: 0;
  - else per opcode.
  Bypassed operands are sign-extended to OUT_W.
REQ-027 Opcode 0: OR. Opcode 1: XOR.
  - Reduction selection as in REQ-026, using red_op_A/red_op_B with INPUT_PRIORITY.
  - Reduction result is 0 or 1, zero-extended.
  - Otherwise bitwise A op B, sign-extended.
REQ-028 Opcode 2: A+B(+cin if FULL_ADDER=="ON"); all terms sign-extended to OUT_W.
REQ-029 Opcode 3: signed A*B, full OUT_W product.
REQ-030 Opcode 4: shift in serial_in.
  - direction=1: {out[OUT_W-2:0], serial_in}.
  - direction=0: {serial_in, out[OUT_W-1:1]}.
REQ-031 Opcode 5: rotate out.
  - direction=1: left by 1.
  - direction=0: right by 1.
REQ-032 Opcode 6 (MAC): out + A*B in signed OUT_W arithmetic.
  - SATURATE=1: clamp to 2^(OUT_W-1)-1 on positive overflow, -2^(OUT_W-1) on negative overflow.
  - SATURATE=0: wrap.
REQ-033 Opcodes 4-6 use the current out value even if it has already been consumed.
REQ-034 On each issue with invalid=1 and no bypass active:
  - leds <= ~leds;
  - err_count increments, saturating at 255.
REQ-035 On each issue with invalid=0, or with a bypass active: leds <= 0; err_count unchanged.
REQ-036 Simultaneous accept and issue in one cycle: stage 1 is overwritten with the new transaction after its previous contents issue; no transaction is lost or duplicated.

Reset
REQ-037 While rst=1, asynchronously: out=0, out_valid=0, s1_valid=0, all stage-1 registers=0, leds=0, err_count=0; in_ready therefore reads 1.
REQ-038 Reset mid-transaction discards stage-1 and output contents; the first accept after rst falls follows REQ-023 timing.

Verification (WIDTH=4, OUT_W=8, out_ready=1 unless stated)
REQ-039 Add: rst pulse; accept A=7, B=-8, cin=1, opcode=2 -> out=0x00, out_valid high one edge after the accept edge; with FULL_ADDER="OFF" -> out=0xFF.
REQ-040 Multiply then MAC: A=-8, B=-8, opcode=3 -> out=64; then opcode=6 with the same operands -> out=127 (SATURATE=1) or -128 (SATURATE=0).
REQ-041 Invalid: red_op_A=1, opcode=3 -> out=0, leds=0xFFFF, err_count=1; repeat -> leds=0x0000, err_count=2; then valid opcode=0, A=1, B=2 -> out=3, leds=0; 256 invalid ops -> err_count holds 255.
REQ-042 Shift/rotate: out=0x01; opcode=4, direction=1, serial_in=1 -> 0x03; then opcode=5, direction=0 -> 0x81.
REQ-043 Backpressure: out_ready=0 after first result; two further accepts -> second fills stage 1, in_ready=0, out stable; raise out_ready -> results delivered in order, none dropped.
REQ-044 Reset mid-stream: assert rst asynchronously with s1_valid=1 and out_valid=1 -> all outputs zero immediately; no result appears after release.

Source files
------------

// File: rtl/alsu_gen2.sv
// Pipelined ALU/shift unit: one stage-1 capture register feeding a result register
// that doubles as shift/rotate/accumulate state, with valid/ready handshakes on both sides.
module alsu_gen2 #(
   parameter int    WIDTH          = 4,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    SATURATE       = 1,
   localparam int   OUT_W          = 2 * WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic signed [1:0]       cin,
   input  logic                    serial_in,
   input  logic                    direction,
   input  logic                    red_op_A,
   input  logic                    red_op_B,
   input  logic                    bypass_A,
   input  logic                    bypass_B,
   input  logic [2:0]              opcode,
   output logic signed [OUT_W-1:0] out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             leds,
   output logic [7:0]              err_count
);

   localparam bit PRI_A = (INPUT_PRIORITY == "A");
   localparam bit FA_ON = (FULL_ADDER == "ON");

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_cin;
   logic             s1_serial_in;
   logic             s1_direction;
   logic             s1_red_a;
   logic             s1_red_b;
   logic             s1_byp_a;
   logic             s1_byp_b;
   logic [2:0]       s1_opcode;

   logic             accept;
   logic             issue;
   logic             invalid;
   logic             bypass;
   logic             red_en;
   logic [WIDTH-1:0] red_operand;
   logic [OUT_W-1:0] a_ext;
   logic [OUT_W-1:0] b_ext;
   logic [OUT_W-1:0] cin_ext;
   logic [OUT_W-1:0] prod;
   logic [OUT_W:0]   mac_sum;
   logic [OUT_W-1:0] result;

   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign issue    = s1_valid && (!out_valid || out_ready);

   assign a_ext   = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
   assign b_ext   = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
   assign cin_ext = {{(OUT_W-2){s1_cin[1]}}, s1_cin};
   // Low OUT_W bits of the product of sign-extended operands equal the signed product.
   assign prod    = a_ext * b_ext;
   // One guard bit exposes signed overflow of the accumulate.
   assign mac_sum = {out[OUT_W-1], out} + {prod[OUT_W-1], prod};

   assign invalid = ((s1_red_a || s1_red_b) && (s1_opcode >= 3'd2)) || (s1_opcode == 3'd7);
   assign bypass  = s1_byp_a || s1_byp_b;
   assign red_en  = s1_red_a || s1_red_b;

   always_comb begin
      red_operand = s1_b;
      if (s1_red_a && s1_red_b)
         red_operand = PRI_A ? s1_a : s1_b;
      else if (s1_red_a)
         red_operand = s1_a;
   end

   always_comb begin
      result = '0;
      if (s1_byp_a && s1_byp_b) begin
         result = PRI_A ? a_ext : b_ext;
      end else if (s1_byp_a) begin
         result = a_ext;
      end else if (s1_byp_b) begin
         result = b_ext;
      end else if (invalid) begin
         result = '0;
      end else begin
         case (s1_opcode)
            3'd0: result = red_en ? {{(OUT_W-1){1'b0}}, |red_operand} : (a_ext | b_ext);
            3'd1: result = red_en ? {{(OUT_W-1){1'b0}}, ^red_operand} : (a_ext ^ b_ext);
            3'd2: result = a_ext + b_ext + (FA_ON ? cin_ext : '0);
            3'd3: result = prod;
            3'd4: result = s1_direction ? {out[OUT_W-2:0], s1_serial_in}
                                        : {s1_serial_in, out[OUT_W-1:1]};
            3'd5: result = s1_direction ? {out[OUT_W-2:0], out[OUT_W-1]}
                                        : {out[0], out[OUT_W-1:1]};
            3'd6: begin
               if ((SATURATE != 0) && (mac_sum[OUT_W] != mac_sum[OUT_W-1]))
                  result = mac_sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
               else
                  result = mac_sum[OUT_W-1:0];
            end
            default: result = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_a         <= '0;
         s1_b         <= '0;
         s1_cin       <= '0;
         s1_serial_in <= 1'b0;
         s1_direction <= 1'b0;
         s1_red_a     <= 1'b0;
         s1_red_b     <= 1'b0;
         s1_byp_a     <= 1'b0;
         s1_byp_b     <= 1'b0;
         s1_opcode    <= '0;
      end else begin
         if (accept) begin
            s1_valid     <= 1'b1;
            s1_a         <= A;
            s1_b         <= B;
            s1_cin       <= cin;
            s1_serial_in <= serial_in;
            s1_direction <= direction;
            s1_red_a     <= red_op_A;
            s1_red_b     <= red_op_B;
            s1_byp_a     <= bypass_A;
            s1_byp_b     <= bypass_B;
            s1_opcode    <= opcode;
         end else if (issue) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         leds      <= '0;
         err_count <= '0;
      end else begin
         if (issue) begin
            out       <= result;
            out_valid <= 1'b1;
            if (invalid && !bypass) begin
               leds <= ~leds;
               if (err_count != 8'hFF)
                  err_count <= err_count + 8'd1;
            end else begin
               leds <= '0;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alsu_gen2.sv
// Bench for alsu_gen2: two instances (default and B-priority/no-carry/wrapping) share
// stimulus; a transaction-level queue model checks every cycle, plus directed tables.
module tb_alsu_gen2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              in_valid, out_ready, serial_in, direction;
   logic              red_op_A, red_op_B, bypass_A, bypass_B;
   logic signed [3:0] A, B;
   logic signed [1:0] cin;
   logic [2:0]        opcode;

   logic              in_ready0, in_ready1, out_valid0, out_valid1;
   logic signed [7:0] out0, out1;
   logic [15:0]       leds0, leds1;
   logic [7:0]        err0, err1;

   alsu_gen2 dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(A), .B(B), .cin(cin),
      .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode), .out(out0),
      .out_valid(out_valid0), .out_ready(out_ready), .leds(leds0), .err_count(err0));

   alsu_gen2 #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .SATURATE(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B), .cin(cin),
      .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode), .out(out1),
      .out_valid(out_valid1), .out_ready(out_ready), .leds(leds1), .err_count(err1));

   typedef struct {
      int a; int b; int cin; bit si; bit dir; bit ra; bit rb; bit ba; bit bb; int op;
   } txn_t;

   typedef struct {
      txn_t t; int exp0; int exp1; int eleds; int eerr;
   } vec_t;

   int   nvec = 0;
   int   nerr = 0;
   txn_t mq[$];
   bit   mov;
   int   mout0, mout1, mleds, merr;
   int   delivered[$];
   vec_t tbl[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sx(int v, int w);
      int m;
      m = v & ((1 << w) - 1);
      if (((m >> (w - 1)) & 1) != 0) m = m - (1 << w);
      return m;
   endfunction

   // Reference: result of one transaction from the rules, given the current out value.
   function automatic int model_alu(txn_t t, int cur, bit pri_a, bit fa, bit sat);
      int a, b, c, o, r, sel;
      bit inv;
      a = sx(t.a, 4); b = sx(t.b, 4); c = sx(t.cin, 2); o = sx(cur, 8);
      inv = ((t.ra || t.rb) && t.op >= 2) || t.op == 7;
      r = 0;
      if (t.ba && t.bb)  r = pri_a ? a : b;
      else if (t.ba)     r = a;
      else if (t.bb)     r = b;
      else if (inv)      r = 0;
      else begin
         case (t.op)
            0, 1: begin
               if (t.ra || t.rb) begin
                  sel = (t.ra && t.rb) ? (pri_a ? t.a : t.b) : (t.ra ? t.a : t.b);
                  sel = sel & 15;
                  r = (t.op == 0) ? int'(sel != 0) : ($countones(sel) % 2);
               end else begin
                  r = (t.op == 0) ? (a | b) : (a ^ b);
               end
            end
            2: r = a + b + (fa ? c : 0);
            3: r = a * b;
            4: r = t.dir ? ((cur << 1) | int'(t.si)) : ((int'(t.si) << 7) | (cur >> 1));
            5: r = t.dir ? ((cur << 1) | ((cur >> 7) & 1)) : (((cur & 1) << 7) | (cur >> 1));
            6: begin
               r = o + a * b;
               if (sat && r > 127)  r = 127;
               if (sat && r < -128) r = -128;
            end
            default: r = 0;
         endcase
      end
      return r & 255;
   endfunction

   task automatic model_reset();
      mq.delete();
      mov = 0; mout0 = 0; mout1 = 0; mleds = 0; merr = 0;
   endtask

   task automatic drive(txn_t t);
      A = 4'(t.a); B = 4'(t.b); cin = 2'(t.cin); serial_in = t.si; direction = t.dir;
      red_op_A = t.ra; red_op_B = t.rb; bypass_A = t.ba; bypass_B = t.bb; opcode = 3'(t.op);
   endtask

   // One clock: check handshake before the edge, advance the model, check outputs after.
   task automatic step();
      txn_t cur, t;
      bit   rdy, acc, iss, inv;
      @(negedge clk);
      cur.a = int'(A); cur.b = int'(B); cur.cin = int'(cin); cur.si = serial_in;
      cur.dir = direction; cur.ra = red_op_A; cur.rb = red_op_B; cur.ba = bypass_A;
      cur.bb = bypass_B; cur.op = int'(opcode);
      rdy = (mq.size() == 0) || !mov || out_ready;
      chk("in_ready0", {31'b0, in_ready0}, {31'b0, rdy});
      chk("in_ready1", {31'b0, in_ready1}, {31'b0, rdy});
      if (out_valid0 && out_ready) delivered.push_back(int'($unsigned(out0)));
      acc = in_valid && rdy;
      iss = (mq.size() > 0) && (!mov || out_ready);
      @(posedge clk);
      #1;
      if (iss) begin
         t = mq.pop_front();
         inv = ((t.ra || t.rb) && t.op >= 2) || t.op == 7;
         if (inv && !(t.ba || t.bb)) begin
            mleds = mleds ^ 16'hFFFF;
            if (merr < 255) merr = merr + 1;
         end else begin
            mleds = 0;
         end
         mout0 = model_alu(t, mout0, 1'b1, 1'b1, 1'b1);
         mout1 = model_alu(t, mout1, 1'b0, 1'b0, 1'b0);
         mov = 1;
      end else if (mov && out_ready) begin
         mov = 0;
      end
      if (acc) mq.push_back(cur);
      chk("out0", 32'($unsigned(out0)), 32'(mout0));
      chk("out1", 32'($unsigned(out1)), 32'(mout1));
      chk("out_valid0", {31'b0, out_valid0}, {31'b0, mov});
      chk("out_valid1", {31'b0, out_valid1}, {31'b0, mov});
      chk("leds", {16'b0, leds0}, 32'(mleds));
      chk("leds1", {16'b0, leds1}, 32'(mleds));
      chk("err_count", {24'b0, err0}, 32'(merr));
      chk("err_count1", {24'b0, err1}, 32'(merr));
   endtask

   function automatic vec_t mk(int a, int b, int c, bit si, bit dir, bit ra, bit rb,
                               bit ba, bit bb, int op, int e0, int e1, int el, int ee);
      vec_t v;
      v.t.a = a; v.t.b = b; v.t.cin = c; v.t.si = si; v.t.dir = dir; v.t.ra = ra;
      v.t.rb = rb; v.t.ba = ba; v.t.bb = bb; v.t.op = op;
      v.exp0 = e0; v.exp1 = e1; v.eleds = el; v.eerr = ee;
      return v;
   endfunction

   // Single transaction with out_ready=1: idle before it, result one edge after accept.
   task automatic apply_vec(vec_t v, int idx);
      drive(v.t);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_latency", idx), {31'b0, out_valid0}, 32'd0);
      step();
      chk($sformatf("vec%0d_valid", idx), {31'b0, out_valid0}, 32'd1);
      chk($sformatf("vec%0d_out0", idx), 32'($unsigned(out0)), 32'(v.exp0));
      chk($sformatf("vec%0d_out1", idx), 32'($unsigned(out1)), 32'(v.exp1));
      chk($sformatf("vec%0d_leds", idx), {16'b0, leds0}, 32'(v.eleds));
      chk($sformatf("vec%0d_err", idx), {24'b0, err0}, 32'(v.eerr));
   endtask

   initial begin
      txn_t t;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      t = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      drive(t);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'($unsigned(out0)), 32'd0);
      chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready0}, 32'd1);
      chk("rst_leds", {16'b0, leds0}, 32'd0);
      chk("rst_err", {24'b0, err0}, 32'd0);
      rst = 1'b0;

      //            a   b   c  si dir ra rb ba bb op  exp0   exp1   leds     err
      tbl.push_back(mk( 7, -8, 1, 0, 0, 0, 0, 0, 0, 2, 8'h00, 8'hFF, 0,       0));
      tbl.push_back(mk(-8, -8, 0, 0, 0, 0, 0, 0, 0, 3, 8'h40, 8'h40, 0,       0));
      tbl.push_back(mk(-8, -8, 0, 0, 0, 0, 0, 0, 0, 6, 8'h7F, 8'h80, 0,       0));
      tbl.push_back(mk( 0,  0, 0, 0, 0, 1, 0, 0, 0, 3, 8'h00, 8'h00, 16'hFFFF, 1));
      tbl.push_back(mk( 0,  0, 0, 0, 0, 1, 0, 0, 0, 3, 8'h00, 8'h00, 0,       2));
      tbl.push_back(mk( 1,  2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h03, 0,       2));
      tbl.push_back(mk( 1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'h01, 0,       2));
      tbl.push_back(mk( 0,  0, 0, 1, 1, 0, 0, 0, 0, 4, 8'h03, 8'h03, 0,       2));
      tbl.push_back(mk( 0,  0, 0, 0, 0, 0, 0, 0, 0, 5, 8'h81, 8'h81, 0,       2));
      tbl.push_back(mk( 7,  3, 0, 0, 0, 1, 1, 0, 0, 1, 8'h01, 8'h00, 0,       2));
      tbl.push_back(mk(-3,  5, 0, 0, 0, 0, 0, 1, 1, 3, 8'hFD, 8'h05, 0,       2));
      tbl.push_back(mk(-8,  1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hF9, 8'hF9, 0,       2));
      tbl.push_back(mk( 0,  2, 0, 0, 0, 0, 0, 0, 1, 7, 8'h02, 8'h02, 0,       2));
      tbl.push_back(mk( 0,  0, 0, 0, 0, 0, 0, 0, 0, 7, 8'h00, 8'h00, 16'hFFFF, 3));
      tbl.push_back(mk(-1, -1,-2, 0, 0, 0, 0, 0, 0, 2, 8'hFC, 8'hFE, 0,       3));
      tbl.push_back(mk(-8,  7, 0, 0, 0, 0, 0, 0, 0, 3, 8'hC8, 8'hC8, 0,       3));
      tbl.push_back(mk(-8,  7, 0, 0, 0, 0, 0, 0, 0, 6, 8'h90, 8'h90, 0,       3));
      tbl.push_back(mk(-8,  7, 0, 0, 0, 0, 0, 0, 0, 6, 8'h80, 8'h58, 0,       3));
      for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

      // Back-to-back invalid operations: error counter must stick at 255.
      t = '{0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
      drive(t);
      in_valid = 1'b1;
      repeat (256) step();
      in_valid = 1'b0;
      repeat (2) step();
      chk("err_saturate", {24'b0, err0}, 32'd255);

      // Backpressure: T1 parks in out, T2 in stage 1, T3 is refused until out_ready rises.
      delivered.delete();
      out_ready = 1'b0;
      t = '{1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      drive(t); in_valid = 1'b1; step();
      t.a = 2; drive(t); step();
      t.a = 3; drive(t);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_in_ready", {31'b0, in_ready0}, 32'd0);
         chk("bp_out_hold", 32'($unsigned(out0)), 32'd1);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("bp_count", 32'(delivered.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("bp_order%0d", i), 32'((i < delivered.size()) ? delivered[i] : -1),
             32'(i + 1));

      // Asynchronous reset with both stages full.
      out_ready = 1'b0;
      t.a = 4; drive(t); in_valid = 1'b1; step();
      t.a = 5; drive(t); step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out", 32'($unsigned(out0)), 32'd0);
      chk("arst_out1", 32'($unsigned(out1)), 32'd0);
      chk("arst_out_valid", {31'b0, out_valid0}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready0}, 32'd1);
      chk("arst_leds", {16'b0, leds0}, 32'd0);
      chk("arst_err", {24'b0, err0}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("arst_no_ghost", {31'b0, out_valid0}, 32'd0);
      apply_vec(mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 2, 8'h05, 8'h05, 0, 0), 99);

      // Randomised traffic against the transaction model.
      for (int i = 0; i < 800; i++) begin
         t.a = int'($urandom_range(0, 15)); t.b = int'($urandom_range(0, 15));
         t.cin = int'($urandom_range(0, 3)); t.si = 1'($urandom_range(0, 1));
         t.dir = 1'($urandom_range(0, 1)); t.ra = ($urandom_range(0, 5) == 0);
         t.rb = ($urandom_range(0, 5) == 0); t.ba = ($urandom_range(0, 7) == 0);
         t.bb = ($urandom_range(0, 7) == 0); t.op = int'($urandom_range(0, 7));
         drive(t);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
